// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and helpers for the UART transmit arbiter: FSM state encoding,
// default escape byte and the round-robin pick used by the RTL.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        WAIT = 2'd3
    } arb_state_e;

    localparam logic [7:0] ESC_CHAR_DEFAULT = 8'h1B;
    localparam int         MAX_REQ          = 8;

    // First index at or after ptr (wrapping at n) with req set; returns ptr when none.
    function automatic logic [2:0] rr_pick_idx(input logic [MAX_REQ-1:0] req,
                                               input logic [2:0]         ptr,
                                               input int                 n);
        logic [2:0] idx;
        logic       found;
        int         j;
        idx   = ptr;
        found = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            if (k < n) begin
                j = int'(ptr) + k;
                if (j >= n) j = j - n;
                if (!found && req[j]) begin
                    idx   = 3'(j);
                    found = 1'b1;
                end
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and UART-side signals of the transmit arbiter.
// Handshake: a byte moves in any cycle where REQ_VALID_I[i] and REQ_READY_O[i] are both high.
interface uart_tx_arbiter_if
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
) ();

    logic [NUM_REQ-1:0]        REQ_VALID_I;
    logic [NUM_REQ-1:0][7:0]   REQ_DATA_I;
    logic [NUM_REQ-1:0]        REQ_LAST_I;
    logic [NUM_REQ-1:0]        REQ_READY_O;
    logic [NUM_REQ-1:0]        GNT_O;
    logic                      LOCKED_O;
    logic                      ABORT_O;
    logic                      UART_WE_O;
    logic [7:0]                UART_DATA_O;
    logic                      UART_ESC_O;
    logic                      UART_TX_READY_I;
    arb_state_e                DBG_STATE_O;

    modport master (
        output REQ_VALID_I, REQ_DATA_I, REQ_LAST_I, UART_TX_READY_I,
        input  REQ_READY_O, GNT_O, LOCKED_O, ABORT_O,
        input  UART_WE_O, UART_DATA_O, UART_ESC_O, DBG_STATE_O
    );

    modport slave (
        input  REQ_VALID_I, REQ_DATA_I, REQ_LAST_I, UART_TX_READY_I,
        output REQ_READY_O, GNT_O, LOCKED_O, ABORT_O,
        output UART_WE_O, UART_DATA_O, UART_ESC_O, DBG_STATE_O
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: one-hot winner and its index.
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0]   o_idx
);

    logic [MAX_REQ-1:0] w_req_ext;
    logic [2:0]         w_ptr_ext;
    logic [2:0]         w_idx_ext;

    always_comb begin
        w_req_ext = MAX_REQ'(i_req);
        w_ptr_ext = 3'(i_ptr);
        w_idx_ext = rr_pick_idx(w_req_ext, w_ptr_ext, NUM_REQ);
        o_idx     = IDX_W'(w_idx_ext);
        o_gnt     = '0;
        if (|i_req) o_gnt = NUM_REQ'(1) << o_idx;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-atomic arbiter sharing one UART transmitter between NUM_REQ byte streams,
// with escape-byte stuffing and a lock timeout for stalled owners.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int         NUM_REQ      = 2,
    parameter logic [7:0] ESC_CHAR     = ESC_CHAR_DEFAULT,
    parameter int         LOCK_TIMEOUT = 1024
) (
    input  logic              CLK_I,
    input  logic              RST_NI,
    uart_tx_arbiter_if.slave  bus
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(LOCK_TIMEOUT);

    arb_state_e         r_state;
    arb_state_e         w_next_state;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [IDX_W-1:0]   r_owner;
    logic [NUM_REQ-1:0] r_gnt;
    logic               r_locked;
    logic               r_stuff;
    logic               r_abort;
    logic [7:0]         r_data;
    logic [CNT_W-1:0]   r_tmo_cnt;

    logic [NUM_REQ-1:0] w_rr_gnt;
    logic [IDX_W-1:0]   w_rr_idx;
    logic [IDX_W-1:0]   w_cand_idx;
    logic               w_cand_valid;
    logic               w_idle;
    logic               w_xfer;
    logic               w_tmo_run;
    logic               w_timeout;
    logic               w_wait_done;
    logic               w_uart_we;
    logic               w_uart_esc;

    function automatic logic [IDX_W-1:0] inc_wrap(input logic [IDX_W-1:0] i);
        return (i == IDX_W'(NUM_REQ - 1)) ? '0 : i + IDX_W'(1);
    endfunction

    rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
        .i_req (bus.REQ_VALID_I),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_rr_gnt),
        .o_idx (w_rr_idx)
    );

    // A locked owner is the only candidate; otherwise the round-robin winner.
    assign w_cand_idx   = r_locked ? r_owner : w_rr_idx;
    assign w_cand_valid = bus.REQ_VALID_I[w_cand_idx];
    assign w_idle       = (r_state == IDLE);
    assign w_xfer       = w_idle && bus.UART_TX_READY_I && w_cand_valid;
    assign w_tmo_run    = w_idle && r_locked && !bus.REQ_VALID_I[r_owner];
    assign w_timeout    = w_tmo_run && (r_tmo_cnt == CNT_W'(LOCK_TIMEOUT - 1));
    assign w_wait_done  = (r_state == WAIT) && bus.UART_TX_READY_I;

    always_comb begin
        bus.REQ_READY_O = '0;
        if (w_xfer && RST_NI) bus.REQ_READY_O[w_cand_idx] = 1'b1;
    end

    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) r_state <= IDLE;
        else         r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_uart_we    = 1'b0;
        w_uart_esc   = 1'b0;
        case (r_state)
            IDLE: if (w_xfer) w_next_state = SEND;
            SEND: begin
                w_uart_we    = 1'b1;
                w_uart_esc   = r_stuff;
                w_next_state = GAP;
            end
            // UART busy flag lags the start pulse, so its ready is not trusted here.
            GAP:  w_next_state = WAIT;
            WAIT: if (bus.UART_TX_READY_I) w_next_state = r_stuff ? SEND : IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            r_rr_ptr  <= '0;
            r_owner   <= '0;
            r_gnt     <= '0;
            r_locked  <= 1'b0;
            r_stuff   <= 1'b0;
            r_abort   <= 1'b0;
            r_data    <= 8'h00;
            r_tmo_cnt <= '0;
        end else begin
            r_abort <= w_timeout && !w_xfer;
            if (w_xfer) begin
                r_data    <= bus.REQ_DATA_I[w_cand_idx];
                r_stuff   <= (bus.REQ_DATA_I[w_cand_idx] == ESC_CHAR);
                r_gnt     <= r_locked ? r_gnt : w_rr_gnt;
                r_owner   <= w_cand_idx;
                r_locked  <= !bus.REQ_LAST_I[w_cand_idx];
                r_tmo_cnt <= '0;
                if (bus.REQ_LAST_I[w_cand_idx]) r_rr_ptr <= inc_wrap(w_cand_idx);
            end else if (w_timeout) begin
                r_locked  <= 1'b0;
                r_rr_ptr  <= inc_wrap(r_owner);
                r_gnt     <= '0;
                r_tmo_cnt <= '0;
            end else begin
                if (w_tmo_run) r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
                if (w_wait_done && r_stuff) r_stuff <= 1'b0;
                if (w_wait_done && !r_stuff && !r_locked) r_gnt <= '0;
            end
        end
    end

    assign bus.GNT_O       = r_gnt;
    assign bus.LOCKED_O    = r_locked;
    assign bus.ABORT_O     = r_abort;
    assign bus.UART_WE_O   = w_uart_we;
    assign bus.UART_ESC_O  = w_uart_esc;
    assign bus.UART_DATA_O = r_data;
    assign bus.DBG_STATE_O = r_state;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART transmit path between `NUM_REQ` byte-stream requesters (e.g. debug-transport responses and host status messages). Grants are packet-atomic: a granted requester keeps the link until it delivers a byte with `LAST` set. Bytes equal to the escape character are sent twice (byte stuffing) so the far end can separate payload from control sequences. The block sits directly in front of the UART top and drives its `WE_I`/`DSEND_I`/`ESC_DETECTED_I` inputs. It paces itself on `TX_READY_O`.

## Interface
- `NUM_REQ`, 2: number of requesters (2..8).
- `ESC_CHAR`, 8'h1B: byte value that is stuffed.
- `LOCK_TIMEOUT`, 1024: idle cycles of the locked requester before its lock is dropped (≥ 2).

- `CLK_I` in 1: clock.
- `RST_NI` in 1: reset. Asynchronous assertion, active-low.
- `REQ_VALID_I` in NUM_REQ: per-requester byte valid.
- `REQ_DATA_I` in NUM_REQ×8: per-requester byte, packed `[NUM_REQ-1:0][7:0]`.
- `REQ_LAST_I` in NUM_REQ: byte is the final byte of its packet.
- `REQ_READY_O` out NUM_REQ: byte accepted this cycle when `VALID` and `READY` are both high.
- `GNT_O` out NUM_REQ: one-hot current owner. All zero when no owner.
- `LOCKED_O` out 1: a packet is in progress.
- `ABORT_O` out 1: one-cycle pulse when a lock times out.
- `UART_WE_O` out 1: one-cycle start pulse to the UART.
- `UART_DATA_O` out 8: byte to the UART. Held stable from the `SEND` cycle until the next `SEND`.
- `UART_ESC_O` out 1: high with `UART_WE_O` when the stuffed escape prefix is sent.
- `UART_TX_READY_I` in 1: UART idle.

## Operation
- FSM states: `IDLE`, `SEND`, `GAP`, `WAIT`.
- **IDLE**
  - Candidate selection:
    - If `LOCKED_O` is high, the candidate is the owner.
    - Otherwise the candidate is the round-robin winner among `REQ_VALID_I`, searching from `rr_ptr`.
  - `REQ_READY_O[cand]` = `UART_TX_READY_I & REQ_VALID_I[cand]`. It is combinational and forced to 0 while `RST_NI` is low.
  - On a transfer:
    - Capture the data byte.
    - Set `stuff` = (byte == `ESC_CHAR`).
    - Set `GNT_O` to the candidate.
    - Set `LOCKED_O` to `!REQ_LAST_I`.
    - If `REQ_LAST_I` is set, set `rr_ptr` = cand+1 modulo `NUM_REQ`.
    - Go to `SEND`.
- **SEND**
  - `UART_WE_O` = 1.
  - If `stuff` is set: `UART_DATA_O` = `ESC_CHAR` and `UART_ESC_O` = 1.
  - Otherwise: `UART_DATA_O` = the captured byte.
  - Go to `GAP`.
- **GAP**
  - Exactly one cycle. `UART_TX_READY_I` is ignored to cover the UART busy-flag latency.
  - Go to `WAIT`.
- **WAIT**
  - Stay until `UART_TX_READY_I` = 1.
  - If `stuff` is set: clear `stuff` and go to `SEND`. This retransmits the byte itself with `UART_ESC_O` = 0.
  - Otherwise go to `IDLE`.
- Lock timeout:
  - Counter runs while in `IDLE` with `LOCKED_O` = 1 and the owner's `REQ_VALID_I` = 0.
  - Counter clears on any owner transfer.
  - When it reaches `LOCK_TIMEOUT`-1:
    - Clear `LOCKED_O`.
    - Pulse `ABORT_O`.
    - Set `rr_ptr` = owner+1.
    - Clear `GNT_O` on the next cycle.
- When not locked, `GNT_O` clears on return to `IDLE` after a `LAST` byte.
- No byte is ever dropped. Payload order within a packet is preserved. Packets from different requesters never interleave.

## Timing
- Reset values:
  - Outputs: `UART_WE_O`=0, `UART_ESC_O`=0, `UART_DATA_O`=8'h00, `GNT_O`=0, `LOCKED_O`=0, `ABORT_O`=0, `REQ_READY_O`=0.
  - Internal: FSM=`IDLE`, `rr_ptr`=0, timeout counter=0, `stuff`=0.
- Latency: transfer in cycle t gives `UART_WE_O` in cycle t+1.
- Minimum byte spacing: 3 cycles plus the UART frame time.
- Throughput: at most one accepted byte per UART frame. A stuffed byte costs two frames.
- Simultaneous valids: the round-robin winner is the first index ≥ `rr_ptr` (wrapping) with valid set. `rr_ptr` wraps from `NUM_REQ`-1 to 0.
- `UART_TX_READY_I` low in `IDLE`: no `READY` is given and state is held.
- A timeout and an owner transfer in the same cycle: the transfer wins and the counter clears.
- Reset mid-packet: all state returns to reset values immediately. The in-flight UART frame is not the arbiter's concern.

## Structure
- `uart_arb_pkg`:
  - `arb_state_e` enum.
  - `ESC_CHAR_DEFAULT` constant.
  - `function automatic` for the round-robin pick, usable by the bench model.
- One sub-module, `rr_pick`: combinational.
  - Inputs: `NUM_REQ` request vector and `rr_ptr`.
  - Outputs: one-hot winner and index.
- Timeout counter width: `$clog2(LOCK_TIMEOUT)`.

## Test plan
- Req0 sends single-byte packet 8'h41 (`LAST`=1) with UART idle -> `REQ_READY_O[0]` in cycle t, `UART_WE_O` with 8'h41 in t+1, `UART_ESC_O`=0.
- Req0 and req1 both valid with single-byte `LAST` packets, `rr_ptr`=0 -> order is 0,1,0,1. `GNT_O` alternates 01,10.
- Req0 sends 3-byte packet while req1 is continuously valid -> all three req0 bytes go out before any req1 byte. `LOCKED_O` is high between bytes 1 and 3.
- Req1 sends 8'h1B -> two WE pulses, first 8'h1B with `UART_ESC_O`=1, second 8'h1B with `UART_ESC_O`=0. A single `READY` is given.
- Req0 sends 1 non-`LAST` byte then drops valid, `LOCK_TIMEOUT`=16 -> `ABORT_O` pulses 16 idle cycles later. Req1 is granted next.
- Reset asserted while in `WAIT` with `stuff`=1 -> outputs return to reset values asynchronously. No second WE pulse after release.
